// File: rtl/iter_divider.sv
// ============================================================================
// Module      : iter_divider
// Description : Iterative restoring radix-2 divider for 33-bit two's
//               complement operands (signedness folded in by the EXE stage).
//               Quotient and remainder are returned sign-extended on a
//               byte-padded result bus together with a one-cycle valid pulse.
//               Optional macro DIV_FAST_ZERO_EN adds a one-cycle path when
//               the dividend or the divisor is zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iter_divider #(
    parameter int W  = 33,
    parameter int OW = 40
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [W-1:0]      s_axis_dividend_tdata,
    input  logic              s_axis_dividend_tvalid,
    input  logic [W-1:0]      s_axis_divisor_tdata,
    input  logic              s_axis_divisor_tvalid,
    output logic              s_axis_tready,
    input  logic              cancel,
    output logic [2*OW-1:0]   m_axis_dout_tdata,
    output logic              m_axis_dout_tvalid
);

    localparam int                 C_CNT_W = $clog2(W);
    localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(W - 1);

    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_CALC = 2'd1;
    localparam logic [1:0] C_FIX  = 2'd2;
`ifdef DIV_FAST_ZERO_EN
    localparam logic [1:0] C_DONE = 2'd3;
`endif

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [C_CNT_W-1:0] r_cnt;
    logic               r_sd;
    logic               r_sq;
    logic               r_dz;
    logic [W-1:0]       r_dvd;      // dividend magnitude, becomes the quotient
    logic [W-1:0]       r_dvs;      // divisor magnitude
    logic [W:0]         r_rem;      // partial remainder
    logic [2*OW-1:0]    r_tdata;
    logic               r_tvalid;

    logic               w_accept;
    logic               w_emit;
    logic               w_last;
    logic [W-1:0]       w_dividend_abs;
    logic [W-1:0]       w_divisor_abs;
    logic [W+1:0]       w_shift;
    logic [W:0]         w_sub;
    logic               w_ge;
    logic [W-1:0]       w_q_fix;
    logic [W-1:0]       w_q_res;
    logic [W-1:0]       w_r_mag;
    logic [W-1:0]       w_r_fix;
    logic [OW-1:0]      w_q_ext;
    logic [OW-1:0]      w_r_ext;
`ifdef DIV_FAST_ZERO_EN
    logic               w_fast;
`endif

    // Operand magnitudes; the most negative value maps onto 2^(W-1) unsigned.
    assign w_dividend_abs = s_axis_dividend_tdata[W-1] ? -s_axis_dividend_tdata
                                                       :  s_axis_dividend_tdata;
    assign w_divisor_abs  = s_axis_divisor_tdata[W-1]  ? -s_axis_divisor_tdata
                                                       :  s_axis_divisor_tdata;

    // One restoring step: shift the next dividend bit in, trial-subtract.
    assign w_shift = {r_rem, r_dvd[W-1]};
    assign w_ge    = (w_shift >= {2'b00, r_dvs});
    assign w_sub   = w_shift[W:0] - {1'b0, r_dvs};
    assign w_last  = (r_cnt == C_LAST);

`ifdef DIV_FAST_ZERO_EN
    assign w_fast  = (s_axis_dividend_tdata == '0) || (s_axis_divisor_tdata == '0);
    // The fast path never iterates, so the remainder magnitude is the
    // latched dividend magnitude (zero when the dividend is zero).
    assign w_r_mag = (r_state == C_DONE) ? r_dvd : r_rem[W-1:0];
`else
    assign w_r_mag = r_rem[W-1:0];
`endif

    // Sign fix. With a zero divisor every step subtracts nothing, so the
    // remainder magnitude equals |dividend| and the fix restores the raw
    // dividend; only the quotient needs forcing to all ones.
    assign w_q_fix = r_sq ? -r_dvd : r_dvd;
    assign w_q_res = r_dz ? '1 : w_q_fix;
    assign w_r_fix = r_sd ? -w_r_mag : w_r_mag;
    assign w_q_ext = OW'($signed(w_q_res));
    assign w_r_ext = OW'($signed(w_r_fix));

    assign s_axis_tready      = (r_state == C_IDLE);
    assign m_axis_dout_tdata  = r_tdata;
    assign m_axis_dout_tvalid = r_tvalid;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= C_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; cancel overrides both acceptance and completion.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_emit      = 1'b0;
        case (r_state)
            C_IDLE: begin
                if (s_axis_dividend_tvalid && s_axis_divisor_tvalid && !cancel) begin
                    w_accept    = 1'b1;
                    w_state_nxt = C_CALC;
`ifdef DIV_FAST_ZERO_EN
                    if (w_fast) begin
                        w_state_nxt = C_DONE;
                    end
`endif
                end
            end
            C_CALC: begin
                if (cancel) begin
                    w_state_nxt = C_IDLE;
                end else if (w_last) begin
                    w_state_nxt = C_FIX;
                end
            end
            C_FIX: begin
                w_emit      = !cancel;
                w_state_nxt = C_IDLE;
            end
`ifdef DIV_FAST_ZERO_EN
            C_DONE: begin
                w_emit      = !cancel;
                w_state_nxt = C_IDLE;
            end
`endif
            default: begin
                w_state_nxt = C_IDLE;
            end
        endcase
    end

    // Datapath: operand capture, one quotient bit per CALC cycle, result register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_sd     <= 1'b0;
            r_sq     <= 1'b0;
            r_dz     <= 1'b0;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_rem    <= '0;
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
        end else begin
            r_tvalid <= 1'b0;
            if (w_accept) begin
                r_sd  <= s_axis_dividend_tdata[W-1];
                r_sq  <= s_axis_dividend_tdata[W-1] ^ s_axis_divisor_tdata[W-1];
                r_dz  <= (s_axis_divisor_tdata == '0);
                r_dvd <= w_dividend_abs;
                r_dvs <= w_divisor_abs;
                r_rem <= '0;
                r_cnt <= '0;
            end else if ((r_state == C_CALC) && !cancel) begin
                r_rem <= w_ge ? w_sub : w_shift[W:0];
                r_dvd <= {r_dvd[W-2:0], w_ge};
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_emit) begin
                r_tdata  <= {w_q_ext, w_r_ext};
                r_tvalid <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_iter_divider.sv
// ============================================================================
// Module      : tb_iter_divider
// Description : Self-checking bench for iter_divider. Expected results come
//               from a 64-bit integer reference model and are queued when a
//               request is driven, then popped when the result pulse appears.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iter_divider;

    localparam int W  = 33;
    localparam int OW = 40;

    logic            clk = 1'b0;
    logic            reset;
    logic [W-1:0]    s_axis_dividend_tdata;
    logic            s_axis_dividend_tvalid;
    logic [W-1:0]    s_axis_divisor_tdata;
    logic            s_axis_divisor_tvalid;
    logic            s_axis_tready;
    logic            cancel;
    logic [2*OW-1:0] m_axis_dout_tdata;
    logic            m_axis_dout_tvalid;

    int checks = 0;
    int errors = 0;

    logic [2*OW-1:0] sb_data[$];
    int              sb_lat[$];
    logic [2*OW-1:0] last_exp = '0;

    iter_divider #(.W(W), .OW(OW)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .s_axis_dividend_tdata  (s_axis_dividend_tdata),
        .s_axis_dividend_tvalid (s_axis_dividend_tvalid),
        .s_axis_divisor_tdata   (s_axis_divisor_tdata),
        .s_axis_divisor_tvalid  (s_axis_divisor_tvalid),
        .s_axis_tready          (s_axis_tready),
        .cancel                 (cancel),
        .m_axis_dout_tdata      (m_axis_dout_tdata),
        .m_axis_dout_tvalid     (m_axis_dout_tvalid)
    );

    always #5 clk = ~clk;

    // Reference: truncating signed division; zero divisor gives all-ones
    // quotient and the dividend as remainder.
    function automatic logic [2*OW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sb == 0) begin
            q = -1;
            r = sa;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
        return {q[OW-1:0], r[OW-1:0]};
    endfunction

    function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef DIV_FAST_ZERO_EN
        if (a == '0 || b == '0) return 1;
`endif
        return W + 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one request for one cycle; optionally queue its expected result.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit push, input string tag);
        s_axis_dividend_tdata  = a;
        s_axis_divisor_tdata   = b;
        s_axis_dividend_tvalid = 1'b1;
        s_axis_divisor_tvalid  = 1'b1;
        checks++;
        assert (s_axis_tready === 1'b1) else begin
            errors++;
            $error("FAIL %s_ready observed=%b expected=1", tag, s_axis_tready);
        end
        if (push) begin
            sb_data.push_back(model(a, b));
            sb_lat.push_back(exp_lat(a, b));
        end
        tick();
        s_axis_dividend_tvalid = 1'b0;
        s_axis_divisor_tvalid  = 1'b0;
        checks++;
        assert (m_axis_dout_tvalid === 1'b0) else begin
            errors++;
            $error("FAIL %s_vlow observed=%b expected=0", tag, m_axis_dout_tvalid);
        end
    endtask

    // Wait (bounded) for the result pulse, then check latency and data.
    task automatic wait_result(input string tag);
        int              n;
        bit              seen;
        logic [2*OW-1:0] exp_d;
        int              exp_n;
        n    = 0;
        seen = 1'b0;
        while (n < 80 && !seen) begin
            tick();
            n++;
            if (m_axis_dout_tvalid === 1'b1) seen = 1'b1;
        end
        checks++;
        assert (seen) else begin
            errors++;
            $error("FAIL %s_timeout observed=no_tvalid expected=tvalid cycles=%0d", tag, n);
        end
        exp_d = sb_data.pop_front();
        exp_n = sb_lat.pop_front();
        last_exp = exp_d;
        if (seen) begin
            checks++;
            assert (n === exp_n) else begin
                errors++;
                $error("FAIL %s_latency observed=%0d expected=%0d", tag, n, exp_n);
            end
            checks++;
            assert (m_axis_dout_tdata === exp_d) else begin
                errors++;
                $error("FAIL %s_data observed=%h expected=%h", tag, m_axis_dout_tdata, exp_d);
            end
            checks++;
            assert (s_axis_tready === 1'b1) else begin
                errors++;
                $error("FAIL %s_ready_at_valid observed=%b expected=1", tag, s_axis_tready);
            end
        end
    endtask

    initial begin
        logic [W-1:0] ta [7];
        logic [W-1:0] tb [7];
        int           bad;

        reset                  = 1'b1;
        cancel                 = 1'b0;
        s_axis_dividend_tdata  = '0;
        s_axis_divisor_tdata   = '0;
        s_axis_dividend_tvalid = 1'b0;
        s_axis_divisor_tvalid  = 1'b0;

        // Reset state.
        tick();
        tick();
        checks++;
        assert (m_axis_dout_tvalid === 1'b0) else begin
            errors++; $error("FAIL rst_tvalid observed=%b expected=0", m_axis_dout_tvalid);
        end
        checks++;
        assert (m_axis_dout_tdata === 80'h0) else begin
            errors++; $error("FAIL rst_tdata observed=%h expected=0", m_axis_dout_tdata);
        end
        checks++;
        assert (s_axis_tready === 1'b1) else begin
            errors++; $error("FAIL rst_tready observed=%b expected=1", s_axis_tready);
        end
        reset = 1'b0;
        tick();

        // 100 / 7 with explicit field checks.
        issue(33'h0_0000_0064, 33'h0_0000_0007, 1'b1, "d100_7");
        wait_result("d100_7");
        checks++;
        assert (m_axis_dout_tdata[71:40] === 32'h0000_000E) else begin
            errors++; $error("FAIL d100_7_q observed=%h expected=0000000e", m_axis_dout_tdata[71:40]);
        end
        checks++;
        assert (m_axis_dout_tdata[31:0] === 32'h0000_0002) else begin
            errors++; $error("FAIL d100_7_r observed=%h expected=00000002", m_axis_dout_tdata[31:0]);
        end
        checks++;
        assert ({m_axis_dout_tdata[79:72], m_axis_dout_tdata[39:32]} === 16'h0000) else begin
            errors++; $error("FAIL d100_7_pad observed=%h expected=0000",
                             {m_axis_dout_tdata[79:72], m_axis_dout_tdata[39:32]});
        end
        tick();
        checks++;
        assert (m_axis_dout_tvalid === 1'b0) else begin
            errors++; $error("FAIL pulse_width observed=%b expected=0", m_axis_dout_tvalid);
        end
        checks++;
        assert (m_axis_dout_tdata === last_exp) else begin
            errors++; $error("FAIL hold_tdata observed=%h expected=%h", m_axis_dout_tdata, last_exp);
        end

        // Signed, boundary and divide-by-zero patterns.
        ta[0] = 33'h1_FFFF_FFF9; tb[0] = 33'h0_0000_0002;   // -7 / 2
        ta[1] = 33'h1_8000_0000; tb[1] = 33'h1_FFFF_FFFF;   // -2^31 / -1
        ta[2] = 33'h1_FFFF_FF9C; tb[2] = 33'h1_FFFF_FFF9;   // -100 / -7
        ta[3] = 33'h0_0000_0064; tb[3] = 33'h1_FFFF_FFF9;   // 100 / -7
        ta[4] = 33'h0_0000_0005; tb[4] = 33'h0_0000_0000;   // 5 / 0
        ta[5] = 33'h1_FFFF_FFF6; tb[5] = 33'h0_0000_0000;   // -10 / 0
        ta[6] = 33'h0_0000_0000; tb[6] = 33'h0_0000_0005;   // 0 / 5
        for (int i = 0; i < 7; i++) begin
            issue(ta[i], tb[i], 1'b1, $sformatf("vec%0d", i));
            wait_result($sformatf("vec%0d", i));
            tick();
        end

        // DIVU max, then a back-to-back request issued in the valid cycle.
        issue(33'h0_FFFF_FFFF, 33'h0_0000_0001, 1'b1, "divu_max");
        wait_result("divu_max");
        checks++;
        assert (m_axis_dout_tdata[72] === 1'b0) else begin
            errors++; $error("FAIL divu_bit72 observed=%b expected=0", m_axis_dout_tdata[72]);
        end
        issue(33'h0_0000_03E8, 33'h1_FFFF_FFFD, 1'b1, "b2b");
        wait_result("b2b");
        tick();

        // Busy re-drive ignored, then cancel mid-calculation.
        issue(33'h0_1234_5678, 33'h0_0000_0011, 1'b0, "cxl");
        tick();
        tick();
        s_axis_dividend_tdata  = 33'h0_0000_0009;
        s_axis_divisor_tdata   = 33'h0_0000_0003;
        s_axis_dividend_tvalid = 1'b1;
        s_axis_divisor_tvalid  = 1'b1;
        checks++;
        assert (s_axis_tready === 1'b0) else begin
            errors++; $error("FAIL busy_tready observed=%b expected=0", s_axis_tready);
        end
        tick();
        s_axis_dividend_tvalid = 1'b0;
        s_axis_divisor_tvalid  = 1'b0;
        repeat (6) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        checks++;
        assert (s_axis_tready === 1'b1) else begin
            errors++; $error("FAIL cancel_tready observed=%b expected=1", s_axis_tready);
        end
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            if (m_axis_dout_tvalid !== 1'b0) bad++;
            tick();
        end
        checks++;
        assert (bad === 0) else begin
            errors++; $error("FAIL cancel_no_pulse observed=%0d expected=0", bad);
        end
        checks++;
        assert (m_axis_dout_tdata === last_exp) else begin
            errors++; $error("FAIL cancel_tdata observed=%h expected=%h", m_axis_dout_tdata, last_exp);
        end

        // Asynchronous reset in the middle of an operation.
        issue(33'h0_0000_0064, 33'h0_0000_0007, 1'b0, "rstmid");
        repeat (19) tick();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        assert (m_axis_dout_tdata === 80'h0) else begin
            errors++; $error("FAIL rstmid_tdata observed=%h expected=0", m_axis_dout_tdata);
        end
        checks++;
        assert (m_axis_dout_tvalid === 1'b0 && s_axis_tready === 1'b1) else begin
            errors++; $error("FAIL rstmid_ctl observed=%b%b expected=01",
                             m_axis_dout_tvalid, s_axis_tready);
        end
        tick();
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (m_axis_dout_tvalid !== 1'b0) bad++;
        end
        checks++;
        assert (bad === 0) else begin
            errors++; $error("FAIL rstmid_no_pulse observed=%0d expected=0", bad);
        end
        issue(33'h0_0000_0064, 33'h0_0000_0007, 1'b1, "post_rst");
        wait_result("post_rst");
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
